// File: rtl/pads_io_seq.sv
// -----------------------------------------------------------------------------
// pads_io_seq
//
// Pad-ring I/O sequencer between the core and the digital I/O pads. After
// reset (or a restart request) every output driver is held tristated for a
// settle period, then driver enables are released one group of channels at
// a time, STEP_CYCLES apart, so the I/O supply never sees all drivers switch
// on at once. Core-to-pad outputs are registered and gated by the group
// enables. Pad inputs are brought into the clock domain through a
// SYNC_STAGES-deep synchroniser that ignores sequencing entirely.
//
// Ports
//   clk_i          single clock
//   rst_i          asynchronous active-high reset
//   seq_restart_i  synchronous request: drop all drivers, rerun the sequence
//   core_oe_i      per-channel output enable from the core
//   core_do_i      per-channel output data from the core
//   pad_oe_o       registered output enable to the pads (1 = drive)
//   pad_do_o       registered output data to the pads (0 when disabled)
//   pad_di_i       raw asynchronous input from the pads
//   core_di_o      synchronised pad input to the core
//   ready_o        registered flag: every group is enabled
// -----------------------------------------------------------------------------
module pads_io_seq #(
    parameter int NUM_CH        = 32,
    parameter int GROUP_SIZE    = 8,
    parameter int SETTLE_CYCLES = 256,
    parameter int STEP_CYCLES   = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              seq_restart_i,
    input  logic [NUM_CH-1:0] core_oe_i,
    input  logic [NUM_CH-1:0] core_do_i,
    output logic [NUM_CH-1:0] pad_oe_o,
    output logic [NUM_CH-1:0] pad_do_o,
    input  logic [NUM_CH-1:0] pad_di_i,
    output logic [NUM_CH-1:0] core_di_o,
    output logic              ready_o
);

    // Number of groups; the last one may be partial. GROUP_SIZE >= NUM_CH
    // collapses to a single group.
    localparam int NG      = (NUM_CH + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int CNT_MAX = (SETTLE_CYCLES > STEP_CYCLES) ? SETTLE_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The counter starts at 0 on edge 0, so it holds N-1 on the N-th edge.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);

    if (GROUP_SIZE < 1) begin : g_bad_group_size
        $error("pads_io_seq: GROUP_SIZE must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("pads_io_seq: SETTLE_CYCLES must be >= 1");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step
        $error("pads_io_seq: STEP_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pads_io_seq: SYNC_STAGES must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_STEP   = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NG-1:0]     grp_en_q, grp_en_d;
    logic [NG-1:0]     grp_next;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] pad_oe_q, pad_oe_d;
    logic [NUM_CH-1:0] pad_do_q, pad_do_d;
    logic              ready_q, ready_d;
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

    // Groups are enabled strictly in order, so grp_en is a thermometer code
    // and the next enable pattern is simply one more bit set at the bottom.
    always_comb begin
        grp_next    = grp_en_q << 1;
        grp_next[0] = 1'b1;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_en
        assign ch_en[c] = grp_en_q[c / GROUP_SIZE];
    end

    // ---------------------------------------------------------------- sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grp_en_d = grp_en_q;

        unique case (state_q)
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    grp_en_d = grp_next;
                    cnt_d    = '0;
                    state_d  = (NG == 1) ? ST_READY : ST_STEP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STEP: begin
                if (cnt_q == STEP_LAST) begin
                    grp_en_d = grp_next;
                    cnt_d    = '0;
                    if (grp_next[NG-1]) begin
                        state_d = ST_READY;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READY: begin
                // Hold until restart or reset.
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase

        // Restart wins over any enable that would land on the same edge and
        // pins the counter at 0 for as long as it is held.
        if (seq_restart_i) begin
            state_d  = ST_SETTLE;
            cnt_d    = '0;
            grp_en_d = '0;
        end
    end

    // ---------------------------------------------------------------- pad output stage
    always_comb begin
        pad_oe_d = core_oe_i & ch_en;
        pad_do_d = core_do_i & ch_en;
        ready_d  = (state_q == ST_READY);
        if (seq_restart_i) begin
            pad_oe_d = '0;
            pad_do_d = '0;
            ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            grp_en_q <= '0;
            pad_oe_q <= '0;
            pad_do_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grp_en_q <= grp_en_d;
            pad_oe_q <= pad_oe_d;
            pad_do_q <= pad_do_d;
            ready_q  <= ready_d;
        end
    end

    // ---------------------------------------------------------------- input synchroniser
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pad_di_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign pad_oe_o  = pad_oe_q;
    assign pad_do_o  = pad_do_q;
    assign ready_o   = ready_q;
    assign core_di_o = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_pads_io_seq.sv
module tb_pads_io_seq;

    // Instance A: main sequencing configuration.
    localparam int A_CH     = 10;
    localparam int A_GS     = 4;
    localparam int A_SETTLE = 8;
    localparam int A_STEP   = 3;
    localparam int A_NG     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rs_a = 1'b0;
    logic [9:0]  coe_a = 10'h3FF;
    logic [9:0]  cdo_a = 10'h2AA;
    logic [9:0]  di_a  = 10'h000;
    logic [9:0]  poe_a, pdo_a, cdi_a;
    logic        rdy_a;

    logic        rs_b = 1'b0;
    logic [3:0]  coe_b = 4'hF;
    logic [3:0]  cdo_b = 4'h3;
    logic [3:0]  di_b  = 4'h0;
    logic [3:0]  poe_b, pdo_b, cdi_b;
    logic        rdy_b;

    logic        rs_c = 1'b0;
    logic [31:0] coe_c = 32'hDEADBEEF;
    logic [31:0] cdo_c = 32'h12345678;
    logic [31:0] di_c  = 32'h0;
    logic [31:0] poe_c, pdo_c, cdi_c;
    logic        rdy_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pads_io_seq #(
        .NUM_CH(A_CH), .GROUP_SIZE(A_GS), .SETTLE_CYCLES(A_SETTLE),
        .STEP_CYCLES(A_STEP), .SYNC_STAGES(2)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .seq_restart_i(rs_a),
        .core_oe_i(coe_a), .core_do_i(cdo_a),
        .pad_oe_o(poe_a), .pad_do_o(pdo_a),
        .pad_di_i(di_a), .core_di_o(cdi_a), .ready_o(rdy_a)
    );

    pads_io_seq #(
        .NUM_CH(4), .GROUP_SIZE(2), .SETTLE_CYCLES(8),
        .STEP_CYCLES(3), .SYNC_STAGES(2)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .seq_restart_i(rs_b),
        .core_oe_i(coe_b), .core_do_i(cdo_b),
        .pad_oe_o(poe_b), .pad_do_o(pdo_b),
        .pad_di_i(di_b), .core_di_o(cdi_b), .ready_o(rdy_b)
    );

    pads_io_seq #(
        .NUM_CH(32), .GROUP_SIZE(64), .SETTLE_CYCLES(1),
        .STEP_CYCLES(16), .SYNC_STAGES(2)
    ) u_c (
        .clk_i(clk), .rst_i(rst), .seq_restart_i(rs_c),
        .core_oe_i(coe_c), .core_do_i(cdo_c),
        .pad_oe_o(poe_c), .pad_do_o(pdo_c),
        .pad_di_i(di_c), .core_di_o(cdi_c), .ready_o(rdy_c)
    );

    typedef struct {
        logic       rs;
        logic [9:0] coe;
        logic [9:0] cdo;
        logic [9:0] eoe;
        logic [9:0] edo;
        logic       erdy;
    } vec_t;

    typedef struct {
        logic [9:0] eoe;
        logic [9:0] edo;
        logic       erdy;
    } exp_t;

    vec_t tbl_main[$];
    vec_t tbl_post[$];
    exp_t sb[$];

    // Channels whose group is enabled as seen after edge k of a sequence:
    // group g first drives after edge SETTLE + g*STEP + 1.
    function automatic logic [9:0] en_mask(input int k);
        logic [9:0] m;
        m = '0;
        for (int g = 0; g < A_NG; g++) begin
            if (k >= A_SETTLE + g * A_STEP + 1) begin
                for (int c = g * A_GS; c < (g + 1) * A_GS && c < A_CH; c++) begin
                    m[c] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    function automatic vec_t mk(input logic rs, input int k,
                                input logic [9:0] coe, input logic [9:0] cdo);
        vec_t v;
        v.rs  = rs;
        v.coe = coe;
        v.cdo = cdo;
        if (rs) begin
            v.eoe  = '0;
            v.edo  = '0;
            v.erdy = 1'b0;
        end else begin
            v.eoe  = coe & en_mask(k);
            v.edo  = cdo & en_mask(k);
            v.erdy = (k >= A_SETTLE + (A_NG - 1) * A_STEP + 1);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge: drive, record expectation, let one
    // rising edge pass, compare, return at the next falling edge.
    task automatic run_row(input vec_t v, input string tag, input int idx);
        exp_t e;
        rs_a  = v.rs;
        coe_a = v.coe;
        cdo_a = v.cdo;
        sb.push_back('{v.eoe, v.edo, v.erdy});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("%s%0d scoreboard empty", tag, idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("%s%0d pad_oe", tag, idx), {22'd0, poe_a}, {22'd0, e.eoe});
            chk($sformatf("%s%0d pad_do", tag, idx), {22'd0, pdo_a}, {22'd0, e.edo});
            chk($sformatf("%s%0d ready", tag, idx), {31'd0, rdy_a}, {31'd0, e.erdy});
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Basic sequence, then a few core patterns once fully enabled.
        for (int k = 1; k <= 16; k++) tbl_main.push_back(mk(1'b0, k, 10'h3FF, 10'h2AA));
        tbl_main.push_back(mk(1'b0, 17, 10'h155, 10'h0F0));
        tbl_main.push_back(mk(1'b0, 18, 10'h2AA, 10'h3FF));
        tbl_main.push_back(mk(1'b0, 19, 10'h000, 10'h3FF));
        tbl_main.push_back(mk(1'b0, 20, 10'h3FF, 10'h2AA));
        // One-cycle restart in READY.
        tbl_main.push_back(mk(1'b1, 0, 10'h3FF, 10'h2AA));
        for (int k = 1; k <= 15; k++) tbl_main.push_back(mk(1'b0, k, 10'h3FF, 10'h2AA));
        // Restart held for 5 cycles: the last restart edge is edge 0.
        for (int i = 0; i < 5; i++) tbl_main.push_back(mk(1'b1, 0, 10'h3FF, 10'h2AA));
        for (int k = 1; k <= 15; k++) tbl_main.push_back(mk(1'b0, k, 10'h3FF, 10'h2AA));
        // Restart landing on group 1's enable edge (edge 11).
        tbl_main.push_back(mk(1'b1, 0, 10'h3FF, 10'h2AA));
        for (int k = 1; k <= 10; k++) tbl_main.push_back(mk(1'b0, k, 10'h3FF, 10'h2AA));
        tbl_main.push_back(mk(1'b1, 0, 10'h3FF, 10'h2AA));
        for (int k = 1; k <= 10; k++) tbl_main.push_back(mk(1'b0, k, 10'h3FF, 10'h2AA));
        // Full rerun after the asynchronous reset.
        for (int k = 1; k <= 16; k++) tbl_post.push_back(mk(1'b0, k, 10'h3FF, 10'h2AA));

        repeat (3) @(posedge clk);
        #1;
        chk("reset pad_oe A", {22'd0, poe_a}, 32'd0);
        chk("reset pad_do A", {22'd0, pdo_a}, 32'd0);
        chk("reset ready A", {31'd0, rdy_a}, 32'd0);
        chk("reset core_di A", {22'd0, cdi_a}, 32'd0);
        chk("reset pad_oe B", {28'd0, poe_b}, 32'd0);
        chk("reset pad_do B", {28'd0, pdo_b}, 32'd0);
        chk("reset ready B", {31'd0, rdy_b}, 32'd0);
        chk("reset pad_oe C", poe_c, 32'd0);
        chk("reset pad_do C", pdo_c, 32'd0);
        chk("reset ready C", {31'd0, rdy_c}, 32'd0);
        chk("reset core_di C", cdi_c, 32'd0);

        @(negedge clk);
        rst  = 1'b0;
        di_a = 10'h3C3;

        fork
            begin : proc_a
                for (int i = 0; i < tbl_main.size(); i++) run_row(tbl_main[i], "main", i);

                // Asynchronous reset between edges 10 and 11.
                chk("pre-reset pad_oe A", {22'd0, poe_a}, 32'h00F);
                chk("pre-reset core_di A", {22'd0, cdi_a}, 32'h3C3);
                #1 rst = 1'b1;
                #1;
                chk("async reset pad_oe A", {22'd0, poe_a}, 32'd0);
                chk("async reset pad_do A", {22'd0, pdo_a}, 32'd0);
                chk("async reset ready A", {31'd0, rdy_a}, 32'd0);
                chk("async reset core_di A", {22'd0, cdi_a}, 32'd0);
                #1 rst = 1'b0;

                for (int i = 0; i < tbl_post.size(); i++) run_row(tbl_post[i], "post", i);
            end
            begin : proc_b
                @(posedge clk);
                #1 di_b = 4'h5;
                @(posedge clk);
                #1 chk("sync B one edge", {28'd0, cdi_b}, 32'h0);
                @(posedge clk);
                #1 chk("sync B two edges", {28'd0, cdi_b}, 32'h5);
                rs_b = 1'b1;
                di_b = 4'hA;
                @(posedge clk);
                #1 chk("sync B restart one edge", {28'd0, cdi_b}, 32'h5);
                @(posedge clk);
                #1 chk("sync B restart two edges", {28'd0, cdi_b}, 32'hA);
                rs_b = 1'b0;
            end
            begin : proc_c
                @(posedge clk);
                #1;
                chk("single grp edge1 pad_oe", poe_c, 32'd0);
                chk("single grp edge1 ready", {31'd0, rdy_c}, 32'd0);
                @(posedge clk);
                #1;
                chk("single grp edge2 pad_oe", poe_c, 32'hDEADBEEF);
                chk("single grp edge2 pad_do", pdo_c, 32'h12345678);
                chk("single grp edge2 ready", {31'd0, rdy_c}, 32'd1);
                rs_c = 1'b1;
                @(posedge clk);
                #1;
                chk("single grp restart pad_oe", poe_c, 32'd0);
                chk("single grp restart ready", {31'd0, rdy_c}, 32'd0);
                rs_c = 1'b0;
                @(posedge clk);
                #1;
                chk("single grp re-edge1 pad_oe", poe_c, 32'd0);
                @(posedge clk);
                #1;
                chk("single grp re-edge2 pad_oe", poe_c, 32'hDEADBEEF);
                chk("single grp re-edge2 ready", {31'd0, rdy_c}, 32'd1);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
